// File: rtl/sync_debounce.sv
// Single-bit input conditioner: P_NSYNC-flop synchronizer followed by a debounce FSM
// producing a clean level plus one-cycle rise/fall pulses. Optional glitch counter: SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce #(
  parameter int unsigned P_NSYNC  = 2,
  parameter int unsigned P_CNT_W  = 16,
  parameter logic        P_DEFVAL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic [P_CNT_W-1:0] thresh,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic               busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0]         glitch_cnt
`endif
);

  localparam int unsigned CNT_W  = P_CNT_W;
  localparam int unsigned NSYNC  = P_NSYNC;
  localparam int unsigned GLCH_W = 8;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } state_e;

  localparam state_e RST_STATE = P_DEFVAL ? ST_HI : ST_LO;

  logic [NSYNC-1:0] sync_q, sync_d;
  logic             s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] t_eff;
  logic [CNT_W:0]   cnt_inc;
  logic             hit;

  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  // Synchronizer shift chain; the last stage feeds the FSM.
  always_comb begin
    sync_d = {sync_q[NSYNC-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {NSYNC{P_DEFVAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[NSYNC-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      level_q <= P_DEFVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: thresh of zero behaves as one; compare one bit wider so cnt+1 never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_eff   = (thresh == '0) ? CNT_W'(1) : thresh;
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    hit     = (cnt_inc >= {1'b0, t_eff});
    unique case (state_q)
      ST_LO: begin
        if (s) begin
          if (t_eff == CNT_W'(1)) begin
            state_d = ST_HI;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (hit) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ST_HI: begin
        if (!s) begin
          if (t_eff == CNT_W'(1)) begin
            state_d = ST_LO;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (hit) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the state being entered; pulses mark a committed flip only.
  always_comb begin
    level_d = (state_d == ST_HI) || (state_d == PEND_LO);
    busy_d  = (state_d == PEND_HI) || (state_d == PEND_LO);
    rise_d  = (state_d == ST_HI) && ((state_q == ST_LO) || (state_q == PEND_HI));
    fall_d  = (state_d == ST_LO) && ((state_q == ST_HI) || (state_q == PEND_LO));
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [GLCH_W-1:0] glitch_q, glitch_d;
  logic              abort_c;

  // An abort is a pending state falling back to the stable state it came from.
  always_comb begin
    abort_c  = ((state_q == PEND_HI) && (state_d == ST_LO)) ||
               ((state_q == PEND_LO) && (state_d == ST_HI));
    glitch_d = glitch_q;
    if (abort_c && (glitch_q != {GLCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLCH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus pushes per-edge expected outputs,
// a monitor pops and compares on every falling edge. Two instances cover P_DEFVAL 0 and 1.
module tb_sync_debounce;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din0, din1;
  logic [CNT_W-1:0] thresh0, thresh1;
  logic             level0, rise0, fall0, busy0;
  logic             level1, rise1, fall1, busy1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]       gcnt0, gcnt1;
`endif

  always #5 clk = ~clk;

  sync_debounce #(.P_NSYNC(2), .P_CNT_W(CNT_W), .P_DEFVAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .thresh(thresh0),
    .level(level0), .rise(rise0), .fall(fall0), .busy(busy0)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gcnt0)
`endif
  );

  sync_debounce #(.P_NSYNC(2), .P_CNT_W(CNT_W), .P_DEFVAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .thresh(thresh1),
    .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gcnt1)
`endif
  );

  // Expected {level, rise, fall, busy} and glitch count after one clock edge.
  typedef struct {
    int         phase;
    int         edge_n;
    bit         sel;
    logic [3:0] exp;
    logic [7:0] gc;
  } item_t;

  item_t sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    phase = 0;
  int    edge_n = 0;
  int    g = 0;

  // Push n expectations, one per rising edge; return just after the last edge.
  task automatic run(input bit sel, input int n, input logic [3:0] e, input int gc);
    item_t it;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      it.phase  = phase;
      it.edge_n = edge_n;
      it.sel    = sel;
      it.exp    = e;
      it.gc     = 8'(gc);
      sb_q.push_back(it);
    end
    #1;
  endtask

  task automatic new_phase(input int p);
    phase  = p;
    edge_n = 0;
  endtask

  // Monitor: compares whatever the stimulus expected for the edge just taken.
  initial begin
    item_t      it;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = it.sel ? {level1, rise1, fall1, busy1} : {level0, rise0, fall0, busy0};
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL outs phase=%0d edge=%0d dut%0d got=%b want=%b (level,rise,fall,busy)",
                   it.phase, it.edge_n, it.sel, act, it.exp);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        total++;
        if ((it.sel ? gcnt1 : gcnt0) !== it.gc) begin
          bad++;
          $display("FAIL glitch_cnt phase=%0d edge=%0d dut%0d got=%0d want=%0d",
                   it.phase, it.edge_n, it.sel, it.sel ? gcnt1 : gcnt0, it.gc);
        end
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    din0    = 1'b0;
    din1    = 1'b1;
    thresh0 = 16'd4;
    thresh1 = 16'd8;

    // Reset values of both instances.
    new_phase(0);
    run(0, 2, 4'b0000, 0);
    run(1, 2, 4'b1000, 0);
    rst_n = 1'b1;

    // Rising step, thresh=4: busy from edge 3, rise at edge 6.
    new_phase(1);
    din0 = 1'b1;
    run(0, 2, 4'b0000, 0);
    run(0, 3, 4'b0001, 0);
    run(0, 1, 4'b1100, 0);
    run(0, 3, 4'b1000, 0);

    // Falling step, thresh=4: single fall at edge 6.
    new_phase(2);
    din0 = 1'b0;
    run(0, 2, 4'b1000, 0);
    run(0, 3, 4'b1001, 0);
    run(0, 1, 4'b0010, 0);
    run(0, 2, 4'b0000, 0);

    // thresh=0 and thresh=1 flip at edge 3 with no busy.
    new_phase(3);
    thresh0 = 16'd0;
    din0    = 1'b1;
    run(0, 2, 4'b0000, 0);
    run(0, 1, 4'b1100, 0);
    run(0, 2, 4'b1000, 0);
    new_phase(4);
    thresh0 = 16'd1;
    din0    = 1'b0;
    run(0, 2, 4'b1000, 0);
    run(0, 1, 4'b0010, 0);
    run(0, 2, 4'b0000, 0);

    // 300 three-cycle glitches at thresh=4: busy 3 cycles, no pulse, count saturates.
    new_phase(5);
    thresh0 = 16'd4;
    g = 0;
    for (int k = 0; k < 300; k++) begin
      edge_n = 0;
      din0 = 1'b1;
      run(0, 2, 4'b0000, g);
      run(0, 1, 4'b0001, g);
      din0 = 1'b0;
      run(0, 2, 4'b0001, g);
      g = (g < 255) ? g + 1 : 255;
      run(0, 3, 4'b0000, g);
    end

    // Reset mid-pend at cnt=5 (between edges), then a full re-debounce at thresh=10.
    new_phase(6);
    thresh0 = 16'd10;
    din0    = 1'b1;
    run(0, 2, 4'b0000, g);
    run(0, 5, 4'b0001, g);
    #6;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    g = 0;
    edge_n = 0;
    run(0, 2, 4'b0000, 0);
    run(0, 9, 4'b0001, 0);
    run(0, 1, 4'b1100, 0);
    run(0, 1, 4'b1000, 0);

    // P_DEFVAL=1 holds level with no pulses, then thresh drops 8->2 mid-pend at cnt=3.
    new_phase(7);
    run(1, 20, 4'b1000, 0);
    new_phase(8);
    din1 = 1'b0;
    run(1, 2, 4'b1000, 0);
    run(1, 3, 4'b1001, 0);
    thresh1 = 16'd2;
    run(1, 1, 4'b0010, 0);
    run(1, 2, 4'b0000, 0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
